// File: rtl/rf_ctrl.sv
// Register-file command controller: accepts LI/ALU/RD commands, drives an
// external register file's read/write ports and returns RD data on a response port.
module rf_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs,
  input  logic [AW-1:0] cmd_rt,
  input  logic [DW-1:0] cmd_imm,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          flag_z,
  output logic          rf_wen,
  output logic [AW-1:0] rf_rw,
  output logic [DW-1:0] rf_busw,
  output logic [AW-1:0] rf_rx,
  output logic [AW-1:0] rf_ry,
  input  logic [DW-1:0] rf_busx,
  input  logic [DW-1:0] rf_busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LI  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_RD  = 3'd7;

  state_t state, nxt;

  logic [2:0]    op_q;
  logic [AW-1:0] rd_q, rs_q, rt_q;
  logic [DW-1:0] imm_q;
  logic          is_wr;

  assign is_wr = (op_q != OP_NOP) && (op_q != OP_RD);
  assign rf_rx = rs_q;
  assign rf_ry = rt_q;
  assign rf_rw = rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      rd_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      imm_q <= '0;
    end else if (state == IDLE && cmd_valid) begin
      op_q  <= cmd_op;
      rd_q  <= cmd_rd;
      rs_q  <= cmd_rs;
      rt_q  <= cmd_rt;
      imm_q <= cmd_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z   <= 1'b0;
      rsp_data <= '0;
    end else if (state == EXEC) begin
      if (is_wr)          flag_z   <= (rf_busw == '0);
      if (op_q == OP_RD)  rsp_data <= rf_busx;
    end
  end

  always_comb begin
    nxt       = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rf_wen    = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) nxt = EXEC;
      end
      EXEC: begin
        rf_wen = is_wr;
        nxt    = (op_q == OP_RD) ? RESP : IDLE;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Operands are the pre-write register values, so rd==rs is safe.
  always_comb begin
    rf_busw = '0;
    unique case (op_q)
      OP_LI:   rf_busw = imm_q;
      OP_ADD:  rf_busw = rf_busx + rf_busy;
      OP_SUB:  rf_busw = rf_busx - rf_busy;
      OP_AND:  rf_busw = rf_busx & rf_busy;
      OP_OR:   rf_busw = rf_busx | rf_busy;
      OP_XOR:  rf_busw = rf_busx ^ rf_busy;
      OP_NOP,
      OP_RD:   rf_busw = '0;
      default: rf_busw = '0;
    endcase
  end

endmodule
